axis_s: RTL and testbench

AXI-Stream slave receiver that is the downstream stage of the `axis_m` master. It accepts beats over a `tvalid`/`tready` handshake and buffers data and `tlast` in a small first-word-fall-through FIFO. It presents the buffered beats on a simple pop interface and tracks packet boundaries, reporting the length and count of completed packets. Backpressure is applied through `tready` when the buffer is full; no beat is ever dropped.

---
 rtl/axis_s.sv | 78 +++++++
 tb/tb_axis_s.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/axis_s.sv
// axis_s: AXI-Stream slave that buffers beats in a FWFT FIFO and tracks packet length/count
// Ports: aclk/areset clock and async reset; tvalid/tready/tdata/tlast stream in;
//        rd_en/rd_valid/rd_data/rd_last pop side; fill occupancy;
//        word_cnt/pkt_len/pkt_done/pkt_cnt packet tracking on the accept side
module axis_s #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 8
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic                     tvalid,
   input  logic                     tlast,
   input  logic [DATA_W-1:0]        tdata,
   output logic                     tready,
   input  logic                     rd_en,
   output logic                     rd_valid,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     rd_last,
   output logic [$clog2(DEPTH):0]   fill,
   output logic [CNT_W-1:0]         word_cnt,
   output logic [CNT_W-1:0]         pkt_len,
   output logic                     pkt_done,
   output logic [CNT_W-1:0]         pkt_cnt
);
   localparam int AW = $clog2(DEPTH);
   logic [DATA_W:0]  mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      fill_q, fill_d;
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d, pkt_len_q, pkt_len_d, pkt_cnt_q, pkt_cnt_d;
   logic             pkt_done_q, pkt_done_d, rst_q;
   logic             accept, pop, last_acc, wc_sat;
   // rst_q holds tready low for the first edge after reset release
   assign tready   = !rst_q && fill_q != (AW+1)'(DEPTH);
   assign rd_valid = fill_q != '0;
   assign {rd_last, rd_data} = rd_valid ? mem_q[rd_ptr_q] : '0;
   assign fill     = fill_q;
   assign word_cnt = word_cnt_q;
   assign pkt_len  = pkt_len_q;
   assign pkt_done = pkt_done_q;
   assign pkt_cnt  = pkt_cnt_q;
   always_comb begin
      accept     = tvalid && tready;
      pop        = rd_en && rd_valid;
      last_acc   = accept && tlast;
      wc_sat     = word_cnt_q == '1;
      wr_ptr_d   = accept ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      fill_d     = fill_q + (AW+1)'(accept) - (AW+1)'(pop);
      word_cnt_d = last_acc ? '0 : (accept && !wc_sat) ? word_cnt_q + CNT_W'(1) : word_cnt_q;
      pkt_len_d  = last_acc ? (wc_sat ? word_cnt_q : word_cnt_q + CNT_W'(1)) : pkt_len_q;
      pkt_cnt_d  = last_acc ? pkt_cnt_q + CNT_W'(1) : pkt_cnt_q;
      pkt_done_d = last_acc;
   end
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         rst_q      <= 1'b1;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         word_cnt_q <= '0;
         pkt_len_q  <= '0;
         pkt_cnt_q  <= '0;
         pkt_done_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         rst_q      <= 1'b0;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fill_q     <= fill_d;
         word_cnt_q <= word_cnt_d;
         pkt_len_q  <= pkt_len_d;
         pkt_cnt_q  <= pkt_cnt_d;
         pkt_done_q <= pkt_done_d;
         if (accept) mem_q[wr_ptr_q] <= {tlast, tdata};
      end
   end
endmodule

// File: tb/tb_axis_s.sv
// tb_axis_s: directed plus random stimulus for axis_s against a queue-based reference model
module tb_axis_s;
   logic aclk = 0, areset = 0, tvalid = 0, tlast = 0, rd_en = 0;
   logic [31:0] tdata = 0;
   logic tready, rd_valid, rd_last, pkt_done;
   logic [31:0] rd_data;
   logic [2:0] fill;
   logic [7:0] word_cnt, pkt_len, pkt_cnt;
   logic tready3, rd_valid3, rd_last3, pkt_done3;
   logic [31:0] rd_data3;
   logic [2:0] fill3;
   logic [2:0] word_cnt3, pkt_len3, pkt_cnt3;
   int n_chk = 0, n_fail = 0;
   logic [32:0] q[$];
   bit m_rst, m_done;
   int m_beats, m_len, m_pkts;
   int words[6] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004, 32'h5555_0005, 32'h6666_0006};

   axis_s #(.DATA_W(32), .DEPTH(4), .CNT_W(8)) dut (
      .aclk(aclk), .areset(areset), .tvalid(tvalid), .tlast(tlast), .tdata(tdata), .tready(tready),
      .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .fill(fill),
      .word_cnt(word_cnt), .pkt_len(pkt_len), .pkt_done(pkt_done), .pkt_cnt(pkt_cnt));
   axis_s #(.DATA_W(32), .DEPTH(4), .CNT_W(3)) dut3 (
      .aclk(aclk), .areset(areset), .tvalid(tvalid), .tlast(tlast), .tdata(tdata), .tready(tready3),
      .rd_en(rd_en), .rd_valid(rd_valid3), .rd_data(rd_data3), .rd_last(rd_last3), .fill(fill3),
      .word_cnt(word_cnt3), .pkt_len(pkt_len3), .pkt_done(pkt_done3), .pkt_cnt(pkt_cnt3));

   always #5 aclk = ~aclk;

   function automatic int sat(int x, int w);
      int lim = (1 << w) - 1;
      return x > lim ? lim : x;
   endfunction

   function automatic bit m_ready();
      return !m_rst && q.size() != 4;
   endfunction

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      logic [32:0] h;
      h = q.size() != 0 ? q[0] : 33'd0;
      chk("tready", tready, m_ready());
      chk("rd_valid", rd_valid, q.size() != 0);
      chk("rd_data", rd_data, h[31:0]);
      chk("rd_last", rd_last, h[32]);
      chk("fill", fill, q.size());
      chk("word_cnt", word_cnt, sat(m_beats, 8));
      chk("pkt_len", pkt_len, sat(m_len, 8));
      chk("pkt_done", pkt_done, m_done);
      chk("pkt_cnt", pkt_cnt, m_pkts % 256);
      chk("tready3", tready3, m_ready());
      chk("rd_data3", rd_data3, h[31:0]);
      chk("fill3", fill3, q.size());
      chk("word_cnt3", word_cnt3, sat(m_beats, 3));
      chk("pkt_len3", pkt_len3, sat(m_len, 3));
      chk("pkt_done3", pkt_done3, m_done);
      chk("pkt_cnt3", pkt_cnt3, m_pkts % 8);
   endtask

   task automatic model_clear();
      q.delete();
      m_rst = 1;
      m_done = 0;
      m_beats = 0;
      m_len = 0;
      m_pkts = 0;
   endtask

   task automatic tick();
      bit acc, pp;
      logic [32:0] dummy;
      @(posedge aclk);
      if (areset) model_clear();
      else begin
         acc = tvalid && m_ready();
         pp = rd_en && q.size() != 0;
         if (pp) dummy = q.pop_front();
         if (acc) q.push_back({tlast, tdata});
         m_done = acc && tlast;
         if (acc && tlast) begin
            m_len = m_beats + 1;
            m_beats = 0;
            m_pkts++;
         end else if (acc) m_beats++;
         m_rst = 0;
      end
      #1 check_all();
   endtask

   task automatic drive(input logic v, input logic l, input logic [31:0] d, input logic re);
      tvalid = v;
      tlast = l;
      tdata = d;
      rd_en = re;
      tick();
   endtask

   task automatic do_reset(int n);
      areset = 1;
      tvalid = 0;
      tlast = 0;
      rd_en = 0;
      model_clear();
      #1 check_all();
      repeat (n) tick();
      areset = 0;
   endtask

   initial begin
      int k;
      logic v, l, re;
      logic [31:0] d;
      #2 do_reset(4);
      drive(0, 0, 0, 0);
      chk("release_tready", tready, 1);
      chk("release_fill", fill, 0);
      // two-beat packet with consumer always ready
      drive(1, 0, 32'haaaa_bbbb, 1);
      chk("two_head0", rd_data, 32'haaaa_bbbb);
      drive(1, 1, 32'hcccc_dddd, 1);
      chk("two_head1", rd_data, 32'hcccc_dddd);
      chk("two_last", rd_last, 1);
      chk("two_done", pkt_done, 1);
      chk("two_len", pkt_len, 2);
      chk("two_cnt", pkt_cnt, 1);
      chk("two_wc", word_cnt, 0);
      drive(0, 0, 0, 1);
      chk("two_done_off", pkt_done, 0);
      // fill to full, stall, single pop releases one slot
      k = 0;
      for (int c = 0; c < 9; c++) begin
         bit a;
         a = m_ready() && k < 6;
         drive(k < 6, 0, words[k < 6 ? k : 5], c == 6);
         if (a) k++;
         if (c == 3) begin
            chk("full_tready", tready, 0);
            chk("full_fill", fill, 4);
         end
         if (c == 6) chk("pop_tready", tready, 1);
         if (c == 7) chk("fifth_in", fill, 4);
      end
      chk("full_head", rd_data, words[1]);
      repeat (6) drive(0, 0, 0, 1);
      // simultaneous push/pop at fill 2, then pops on empty
      drive(1, 0, 32'h0000_00a1, 0);
      drive(1, 0, 32'h0000_00a2, 0);
      drive(1, 0, 32'h0000_00a3, 1);
      chk("sim_fill", fill, 2);
      chk("sim_head", rd_data, 32'h0000_00a2);
      repeat (4) drive(0, 0, 0, 1);
      chk("empty_fill", fill, 0);
      // reset in the middle of a packet
      drive(1, 0, 32'hdead_0001, 0);
      drive(1, 0, 32'hdead_0002, 0);
      do_reset(1);
      chk("mid_wc", word_cnt, 0);
      chk("mid_done", pkt_done, 0);
      drive(0, 0, 0, 0);
      drive(1, 1, 32'hbeef_0001, 1);
      chk("single_len", pkt_len, 1);
      chk("single_cnt", pkt_cnt, 1);
      // counter wrap and length saturation on the narrow instance
      do_reset(1);
      drive(0, 0, 0, 0);
      for (int i = 0; i < 9; i++) drive(1, 1, i, 1);
      chk("wrap_cnt3", pkt_cnt3, 1);
      chk("wrap_cnt8", pkt_cnt, 9);
      for (int i = 0; i < 10; i++) drive(1, i == 9, 32'h100 + i, 1);
      chk("sat_len3", pkt_len3, 7);
      chk("sat_len8", pkt_len, 10);
      // random traffic, master holds beat while stalled
      v = 0; l = 0; d = 0;
      for (int i = 0; i < 500; i++) begin
         if (!(tvalid && !m_ready())) begin
            v = $urandom_range(0, 3) != 0;
            l = $urandom_range(0, 3) == 0;
            d = $urandom;
         end
         re = $urandom_range(0, 2) != 0;
         drive(v, l, d, re);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
